ex_muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the Execute stage, fed by the operands and control latched into the ID/EX pipeline register. It computes all eight M-extension operations with a shared 32-iteration shift datapath. While it computes, `busy` drives the hazard unit to stall IF/ID/EX, and `done` marks the cycle in which `result` is valid for the EX/MEM write.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit and the instruction decoder.
package muldiv_pkg;

   // Number of shift iterations for one multiply or divide.
   localparam int unsigned ITER_COUNT = 32;

   // M-extension operations, encoded as funct3.
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage. Multiply and divide share a
// 64-bit shift register and a 6-bit iteration counter; signs are stripped on entry and
// re-applied on the last iteration so that result is registered when done pulses.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [5:0]      LastIter = 6'(ITER_COUNT - 1);

   muldiv_state_t state_q, state_d;
   muldiv_op_t    op_in, op_q;
   logic          neg_q;
   logic [5:0]    cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opb_q;
   logic [XLEN-1:0]   result_q;

   logic            accept;
   logic            sign_a, sign_b, neg_in;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_part, div_trial;
   logic [2*XLEN-1:0] div_next, iter_next;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, rem, final_res;
   logic              last_iter;

   assign op_in     = muldiv_op_t'(op);
   assign accept    = (state_q == IDLE) && start && !kill;
   assign last_iter = (cnt_q == LastIter);
   assign result    = result_q;

   // Decode operand signs/magnitudes and the preset results for the divide corner cases.
   always_comb begin
      sign_a = 1'b0;
      sign_b = 1'b0;
      unique case (op_in)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            sign_a = srcA[XLEN-1];
            sign_b = srcB[XLEN-1];
         end
         OP_MULHSU: sign_a = srcA[XLEN-1];
         default: ;
      endcase
      // 0x80000000 negates to itself, which is the correct unsigned magnitude.
      mag_a       = sign_a ? -srcA : srcA;
      mag_b       = sign_b ? -srcB : srcB;
      // Remainder follows the dividend; products and quotients follow the sign product.
      neg_in      = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);
      div_zero    = op[2] && (srcB == '0);
      div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) && (srcA == MinNeg) && (srcB == '1);
      special     = div_zero || div_ovf;
      // op[1] selects REM/REMU over DIV/DIVU.
      special_res = div_zero ? (op[1] ? srcA : '1) : (op[1] ? '0 : MinNeg);
   end

   // One shift-add (multiply) or restoring (divide) step on the shared shift register.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
      mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
      // Partial remainder is 33 bits: the old remainder's MSB must survive the shift.
      div_part  = acc_q[2*XLEN-1:XLEN-1];
      div_trial = div_part - {1'b0, opb_q};
      div_next  = div_trial[XLEN] ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      iter_next = op_q[2] ? div_next : mul_next;
   end

   // Sign correction and result selection, applied to the final iteration's output.
   always_comb begin
      prod      = neg_q ? -iter_next : iter_next;
      quot      = neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
      rem       = neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
      final_res = '0;
      unique case (op_q)
         OP_MUL:                        final_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               final_res = quot;
         default:                       final_res = rem;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; kill overrides everything.
   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start) state_d = special ? FINISH : CALC;
            CALC:    if (last_iter) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: busy stalls the pipeline; it drops immediately on kill or reset.
   always_comb begin
      busy = !rst && !kill && (((state_q == IDLE) && start) || (state_q == CALC));
      done = (state_q == FINISH) && !kill;
   end

   // Datapath: operand capture, iteration and result registration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q  <= op_in;
         neg_q <= neg_in;
         cnt_q <= '0;
         // Low half holds the multiplier (multiply) or the dividend/quotient (divide).
         acc_q <= {{XLEN{1'b0}}, mag_a};
         opb_q <= mag_b;
         if (special) begin
            result_q <= special_res;
         end
      end else if ((state_q == CALC) && !kill) begin
         cnt_q <= cnt_q + 6'd1;
         acc_q <= iter_next;
         if (last_iter) begin
            result_q <= final_res;
         end
      end
   end

endmodule
